// File: rtl/lcd_freq_ctrl.sv
// lcd_freq_ctrl
//   Drives an HD44780-compatible character LCD in 8-bit write-only mode.
//   After reset it waits out the LCD power-up time and issues the init
//   commands. Each new frequency word is then converted to decimal and
//   line 1 is rewritten as a right-aligned 5-digit field plus " Hz".
//
// Ports
//   clk        system clock, all logic on posedge
//   reset      asynchronous, active-high reset
//   frequency  unsigned frequency in Hz, valid with new_freq
//   new_freq   single-cycle update pulse
//   lcd_rs     0 = command, 1 = data
//   lcd_rw     tied low (write-only)
//   lcd_e      LCD enable strobe
//   lcd_data   LCD data bus
//   busy       high in every state except IDLE
//
// state   | meaning
// --------+----------------------------------------------------------
// PWRUP   | post-reset wait before the first LCD command
// INIT    | four init commands: 0x38, 0x0C, 0x06, 0x01
// IDLE    | waiting for a pending update
// CONVERT | 16-cycle double-dabble of the captured frequency
// WRITE   | cursor home (0x80), five digit chars, " Hz"
//
// Every write runs SETUP (1 cycle) -> STROBE (EN_CYCLES) -> WAIT.
// rs/data are registered on the edge that enters SETUP and held until
// the next SETUP.
module lcd_freq_ctrl #(
   parameter int POWERUP_CYCLES = 720000,
   parameter int EN_CYCLES      = 24,
   parameter int SETTLE_CYCLES  = 2400,
   parameter int CLEAR_CYCLES   = 96000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] frequency,
   input  logic        new_freq,
   output logic        lcd_rs,
   output logic        lcd_rw,
   output logic        lcd_e,
   output logic [7:0]  lcd_data,
   output logic        busy
);

   typedef enum logic [2:0] {PWRUP, INIT, IDLE, CONVERT, WRITE} state_t;
   typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_WAIT} phase_t;

   state_t          state;
   phase_t          phase;
   logic [31:0]     timer;
   logic [3:0]      idx;
   logic [15:0]     shadow;
   logic            pending;
   logic [15:0]     bin;
   logic [19:0]     bcd;
   logic [15:0]     bcd_adj;
   logic [4:0][7:0] digit_char;
   logic            lead_zero;
   logic            is_clear;
   logic            last_write;

   assign lcd_rw     = 1'b0;
   assign is_clear   = (state == INIT) && (idx == 4'd3);
   assign last_write = (state == INIT) ? (idx == 4'd3) : (idx == 4'd8);

   // The ten-thousands nibble never reaches 5 before the final shift
   // (input <= 65535), so only the lower four nibbles need the +3 step.
   always_comb begin
      bcd_adj = bcd[15:0];
      for (int i = 0; i < 4; i++) begin
         if (bcd[4*i +: 4] > 4'd4) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   // digit_char[4] is ten-thousands; leading zeros blank, units never do
   always_comb begin
      lead_zero  = 1'b1;
      digit_char = '0;
      for (int i = 4; i >= 0; i--) begin
         if (lead_zero && (i != 0) && (bcd[4*i +: 4] == 4'd0)) begin
            digit_char[i] = 8'h20;
         end else begin
            digit_char[i] = {4'h3, bcd[4*i +: 4]};
            lead_zero     = 1'b0;
         end
      end
   end

   // {rs, data} for write number n of the init or update sequence
   function automatic logic [8:0] write_word(input logic            init_seq,
                                             input logic [3:0]      n,
                                             input logic [4:0][7:0] dig);
      if (init_seq) begin
         case (n)
            4'd0:    write_word = 9'h038;
            4'd1:    write_word = 9'h00C;
            4'd2:    write_word = 9'h006;
            default: write_word = 9'h001;
         endcase
      end else begin
         case (n)
            4'd0:    write_word = 9'h080;
            4'd1:    write_word = {1'b1, dig[4]};
            4'd2:    write_word = {1'b1, dig[3]};
            4'd3:    write_word = {1'b1, dig[2]};
            4'd4:    write_word = {1'b1, dig[1]};
            4'd5:    write_word = {1'b1, dig[0]};
            4'd6:    write_word = 9'h120;
            4'd7:    write_word = 9'h148;
            default: write_word = 9'h17A;
         endcase
      end
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= PWRUP;
         phase    <= PH_SETUP;
         timer    <= 32'(POWERUP_CYCLES - 1);
         idx      <= '0;
         shadow   <= '0;
         pending  <= 1'b0;
         bin      <= '0;
         bcd      <= '0;
         lcd_e    <= 1'b0;
         lcd_rs   <= 1'b0;
         lcd_data <= '0;
         busy     <= 1'b1;
      end else begin
         case (state)
            PWRUP: begin
               if (timer == '0) begin
                  state              <= INIT;
                  phase              <= PH_SETUP;
                  idx                <= '0;
                  {lcd_rs, lcd_data} <= write_word(1'b1, 4'd0, digit_char);
               end else begin
                  timer <= timer - 32'd1;
               end
            end
            IDLE: begin
               if (pending) begin
                  pending <= 1'b0;
                  bin     <= shadow;
                  bcd     <= '0;
                  timer   <= 32'd15;
                  state   <= CONVERT;
                  busy    <= 1'b1;
               end
            end
            CONVERT: begin
               bcd <= {bcd[18:16], bcd_adj, bin[15]};
               bin <= {bin[14:0], 1'b0};
               // the cursor-home command is constant, so its SETUP can
               // start on the same edge as the final shift
               if (timer == '0) begin
                  state              <= WRITE;
                  phase              <= PH_SETUP;
                  idx                <= '0;
                  {lcd_rs, lcd_data} <= write_word(1'b0, 4'd0, digit_char);
               end else begin
                  timer <= timer - 32'd1;
               end
            end
            INIT, WRITE: begin
               case (phase)
                  PH_SETUP: begin
                     lcd_e <= 1'b1;
                     timer <= 32'(EN_CYCLES - 1);
                     phase <= PH_STROBE;
                  end
                  PH_STROBE: begin
                     if (timer == '0) begin
                        lcd_e <= 1'b0;
                        timer <= is_clear ? 32'(CLEAR_CYCLES - 1) : 32'(SETTLE_CYCLES - 1);
                        phase <= PH_WAIT;
                     end else begin
                        timer <= timer - 32'd1;
                     end
                  end
                  PH_WAIT: begin
                     if (timer != '0) begin
                        timer <= timer - 32'd1;
                     end else if (last_write) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end else begin
                        idx                <= idx + 4'd1;
                        phase              <= PH_SETUP;
                        {lcd_rs, lcd_data} <= write_word(state == INIT, idx + 4'd1, digit_char);
                     end
                  end
                  default: phase <= PH_SETUP;
               endcase
            end
            default: state <= PWRUP;
         endcase

         // capture after the FSM so a same-cycle set beats IDLE's clear
         if (new_freq) begin
            shadow  <= frequency;
            pending <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_lcd_freq_ctrl.sv
// tb_lcd_freq_ctrl
//   Directed bench for lcd_freq_ctrl with short timing parameters.
//   Expected byte streams and cycle positions are written out by hand.
module tb_lcd_freq_ctrl;

   localparam int POWERUP = 10;
   localparam int EN      = 2;
   localparam int SETTLE  = 4;
   localparam int CLEAR   = 8;

   logic        clk       = 1'b0;
   logic        reset     = 1'b1;
   logic [15:0] frequency = '0;
   logic        new_freq  = 1'b0;
   logic        lcd_rs;
   logic        lcd_rw;
   logic        lcd_e;
   logic [7:0]  lcd_data;
   logic        busy;

   int n_checks = 0;
   int n_pass   = 0;

   lcd_freq_ctrl #(
      .POWERUP_CYCLES (POWERUP),
      .EN_CYCLES      (EN),
      .SETTLE_CYCLES  (SETTLE),
      .CLEAR_CYCLES   (CLEAR)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .frequency (frequency),
      .new_freq  (new_freq),
      .lcd_rs    (lcd_rs),
      .lcd_rw    (lcd_rw),
      .lcd_e     (lcd_e),
      .lcd_data  (lcd_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse(input logic [15:0] f);
      frequency = f;
      new_freq  = 1'b1;
      tick(1);
      new_freq  = 1'b0;
   endtask

   // Called #1 after the edge that enters SETUP; returns #1 after the edge
   // ending this write's WAIT.
   task automatic do_write(input string tag, input logic [7:0] b, input logic rs, input int wt);
      int   hi;
      logic hold_ok;
      check($sformatf("%s_setup", tag), {22'b0, lcd_rs, lcd_e, lcd_data}, {22'b0, rs, 1'b0, b});
      hold_ok = 1'b1;
      hi      = 0;
      tick(1);
      while (lcd_e && hi < 50) begin
         if (lcd_data != b || lcd_rs != rs) hold_ok = 1'b0;
         hi++;
         tick(1);
      end
      check($sformatf("%s_en", tag), hi, EN);
      for (int j = 0; j < wt; j++) begin
         if (lcd_e || lcd_data != b || lcd_rs != rs || !busy) hold_ok = 1'b0;
         tick(1);
      end
      check($sformatf("%s_hold", tag), hold_ok, 1);
   endtask

   // Called at the negedge right after reset is released.
   task automatic do_init();
      tick(POWERUP - 1);
      check("pwrup_quiet", {lcd_e, lcd_rs, busy, lcd_data}, {1'b0, 1'b0, 1'b1, 8'h00});
      tick(1);
      do_write("init0", 8'h38, 1'b0, SETTLE);
      do_write("init1", 8'h0C, 1'b0, SETTLE);
      do_write("init2", 8'h06, 1'b0, SETTLE);
      do_write("init3", 8'h01, 1'b0, CLEAR);
      check("init_idle", busy, 0);
   endtask

   // Called #1 after edge k (pending just set, FSM in IDLE).
   // dig[4] is the ten-thousands character.
   task automatic expect_update(input string tag, input logic [4:0][7:0] dig);
      check($sformatf("%s_idle", tag), busy, 0);
      tick(1);
      check($sformatf("%s_busy", tag), busy, 1);
      tick(15);
      check($sformatf("%s_conv", tag), {lcd_e, busy}, 2'b01);
      tick(1);
      do_write($sformatf("%s_home", tag), 8'h80, 1'b0, SETTLE);
      for (int i = 4; i >= 0; i--) begin
         do_write($sformatf("%s_d%0d", tag, i), dig[i], 1'b1, SETTLE);
      end
      do_write($sformatf("%s_sp", tag), 8'h20, 1'b1, SETTLE);
      do_write($sformatf("%s_h", tag), 8'h48, 1'b1, SETTLE);
      do_write($sformatf("%s_z", tag), 8'h7A, 1'b1, SETTLE);
      check($sformatf("%s_done", tag), busy, 0);
   endtask

   task automatic wait_e(input logic val, input string tag);
      int n;
      n = 0;
      while (lcd_e != val && n < 100) begin
         tick(1);
         n++;
      end
      check(tag, lcd_e, val);
   endtask

   initial begin
      #12;
      check("rst_outs", {lcd_e, lcd_rs, lcd_rw, busy, lcd_data}, {1'b0, 1'b0, 1'b0, 1'b1, 8'h00});
      check("rst_pending", dut.pending, 0);
      @(negedge clk);
      reset = 1'b0;

      // init sequence
      do_init();
      tick(3);
      check("idle_hold", busy, 0);

      // single update and digit extremes
      pulse(16'd440);
      expect_update("f440", {8'h20, 8'h20, 8'h34, 8'h34, 8'h30});
      pulse(16'd0);
      expect_update("f0", {8'h20, 8'h20, 8'h20, 8'h20, 8'h30});
      pulse(16'd65535);
      expect_update("f65535", {8'h36, 8'h35, 8'h35, 8'h33, 8'h35});
      pulse(16'd10000);
      expect_update("f10000", {8'h31, 8'h30, 8'h30, 8'h30, 8'h30});

      // coalescing: two pulses during an update yield one more update
      pulse(16'd440);
      fork
         expect_update("co440", {8'h20, 8'h20, 8'h34, 8'h34, 8'h30});
         begin
            tick(30);
            pulse(16'd1000);
            tick(10);
            pulse(16'd2000);
         end
      join
      expect_update("co2000", {8'h20, 8'h32, 8'h30, 8'h30, 8'h30});
      tick(20);
      check("co_quiet", busy, 0);

      // new_freq in the cycle IDLE consumes pending
      pulse(16'd100);
      frequency = 16'd200;
      new_freq  = 1'b1;
      fork
         expect_update("col100", {8'h20, 8'h20, 8'h31, 8'h30, 8'h30});
         begin
            tick(1);
            new_freq = 1'b0;
         end
      join
      expect_update("col200", {8'h20, 8'h20, 8'h32, 8'h30, 8'h30});

      // reset during the first digit strobe, with an update pending
      pulse(16'd440);
      wait_e(1'b1, "rst_e_rise1");
      wait_e(1'b0, "rst_e_fall1");
      wait_e(1'b1, "rst_e_rise2");
      pulse(16'd777);
      check("rst_pre", {lcd_e, lcd_rs, lcd_data, dut.pending}, {1'b1, 1'b1, 8'h20, 1'b1});
      #2;
      reset = 1'b1;
      #1;
      check("rst_async_outs", {lcd_e, lcd_rs, lcd_data}, 10'h000);
      check("rst_async_busy", busy, 1);
      check("rst_async_pending", dut.pending, 0);
      tick(2);
      check("rst_held", {lcd_e, lcd_rs, busy, lcd_data}, {1'b0, 1'b0, 1'b1, 8'h00});
      @(negedge clk);
      reset = 1'b0;
      do_init();
      tick(30);
      check("rst_no_pending", busy, 0);

      // update requested during power-up wait
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      fork
         do_init();
         begin
            tick(2);
            pulse(16'd1234);
         end
      join
      expect_update("f1234", {8'h20, 8'h31, 8'h32, 8'h33, 8'h34});
      tick(10);
      check("end_quiet", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
